// File: rtl/alu_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | alu_ctrl_pkg: opcode, funct, control-word and state encodings      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package alu_ctrl_pkg;

  localparam logic [2:0] ALUOP_ADD   = 3'd0;
  localparam logic [2:0] ALUOP_SUB   = 3'd1;
  localparam logic [2:0] ALUOP_RTYPE = 3'd2;
  localparam logic [2:0] ALUOP_OP3   = 3'd3;
  localparam logic [2:0] ALUOP_OP4   = 3'd4;
  localparam logic [2:0] ALUOP_OP5   = 3'd5;
  localparam logic [2:0] ALUOP_OP6   = 3'd6;
  localparam logic [2:0] ALUOP_OP7   = 3'd7;

  localparam logic [5:0] FUNCT_MULT = 6'd24;
  localparam logic [5:0] FUNCT_AND  = 6'd36;
  localparam logic [5:0] FUNCT_OR   = 6'd37;
  localparam logic [5:0] FUNCT_ADD  = 6'd32;
  localparam logic [5:0] FUNCT_SUB  = 6'd34;
  localparam logic [5:0] FUNCT_SLT  = 6'd42;

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_OP3  = 4'b0011;
  localparam logic [3:0] CTRL_OP6  = 4'b0100;
  localparam logic [3:0] CTRL_OP7  = 4'b0101;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_MULT = 4'b1000;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MULT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
// +--------------------------------------------------------------------+
// | alu_ctrl_decode: combinational ALUOp/funct -> {ctrl, legal, mult}  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 3,
  parameter int FUNCT_W = 6
) (
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic [FUNCT_W-1:0] funct_i,
  output logic [3:0]         ctrl_o,
  output logic               legal_o,
  output logic               is_mult_o
);

  logic w_op_hi;
  logic w_funct_hi;

  // Any set bit above the 3-bit opcode means ALUOp >= 8; above bit 5 means an unknown funct.
  generate
    if (ALUOP_W > 3) begin : g_op_hi
      assign w_op_hi = |ALUOp_i[ALUOP_W-1:3];
    end else begin : g_op_nohi
      assign w_op_hi = 1'b0;
    end
    if (FUNCT_W > 6) begin : g_funct_hi
      assign w_funct_hi = |funct_i[FUNCT_W-1:6];
    end else begin : g_funct_nohi
      assign w_funct_hi = 1'b0;
    end
  endgenerate

  always_comb begin
    ctrl_o    = CTRL_AND;
    legal_o   = 1'b1;
    is_mult_o = 1'b0;
    if (!w_op_hi) begin
      case (ALUOp_i[2:0])
        ALUOP_ADD: ctrl_o = CTRL_ADD;
        ALUOP_SUB: ctrl_o = CTRL_SUB;
        ALUOP_RTYPE: begin
          if (w_funct_hi) begin
            legal_o = 1'b0;
          end else begin
            case (funct_i[5:0])
              FUNCT_MULT: begin
                ctrl_o    = CTRL_MULT;
                is_mult_o = 1'b1;
              end
              FUNCT_AND: ctrl_o  = CTRL_AND;
              FUNCT_OR:  ctrl_o  = CTRL_OR;
              FUNCT_ADD: ctrl_o  = CTRL_ADD;
              FUNCT_SUB: ctrl_o  = CTRL_SUB;
              FUNCT_SLT: ctrl_o  = CTRL_SLT;
              default:   legal_o = 1'b0;
            endcase
          end
        end
        ALUOP_OP3: ctrl_o = CTRL_OP3;
        ALUOP_OP4: ctrl_o = CTRL_ADD;
        ALUOP_OP5: ctrl_o = CTRL_SLT;
        ALUOP_OP6: ctrl_o = CTRL_OP6;
        ALUOP_OP7: ctrl_o = CTRL_OP7;
        default:   ctrl_o = CTRL_AND;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_ctrl_sequencer.sv
// +--------------------------------------------------------------------+
// | alu_ctrl_sequencer: registered ALU control with multi-cycle mult   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_ctrl_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W  = 3,
  parameter int FUNCT_W  = 6,
  parameter int CTRL_W   = 4,
  parameter int MULT_LAT = 4,
  parameter int ERR_W    = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic               flush_i,
  output logic [CTRL_W-1:0]  ALUCtrl_o,
  output logic               valid_o,
  output logic               busy_o,
  output logic               illegal_o,
  output logic [ERR_W-1:0]   err_cnt_o
);

  localparam int              CNT_W    = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_LAT - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             valid_q, valid_d;
  logic             illegal_q, illegal_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic [3:0] w_ctrl;
  logic       w_legal;
  logic       w_is_mult;
  logic       w_accept;

  alu_ctrl_decode #(
    .ALUOP_W (ALUOP_W),
    .FUNCT_W (FUNCT_W)
  ) u_decode (
    .ALUOp_i   (ALUOp_i),
    .funct_i   (funct_i),
    .ctrl_o    (w_ctrl),
    .legal_o   (w_legal),
    .is_mult_o (w_is_mult)
  );

  assign ready_o  = (state_q == S_IDLE);
  assign w_accept = valid_i && ready_o && !flush_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    valid_d   = 1'b0;
    illegal_d = 1'b0;
    err_d     = err_q;
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (state_q == S_IDLE) begin
      if (w_accept) begin
        if (!w_legal) begin
          illegal_d = 1'b1;
          if (err_q != '1) err_d = err_q + ERR_W'(1);
        end else if (w_is_mult) begin
          ctrl_d  = w_ctrl;
          state_d = S_MULT;
          cnt_d   = '0;
          valid_d = (CNT_LAST == '0);
        end else begin
          ctrl_d  = w_ctrl;
          valid_d = 1'b1;
        end
      end
    end else begin
      // valid_o is registered, so it is raised one cycle ahead of cnt reaching the last step.
      if (cnt_q == CNT_LAST) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        valid_d = ((cnt_q + CNT_W'(1)) == CNT_LAST);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      err_q     <= err_d;
    end
  end

  assign ALUCtrl_o = CTRL_W'(ctrl_q);
  assign valid_o   = valid_q;
  assign busy_o    = (state_q == S_MULT);
  assign illegal_o = illegal_q;
  assign err_cnt_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl_sequencer.sv
// +--------------------------------------------------------------------+
// | tb_alu_ctrl_sequencer: directed stimulus with scoreboard monitor   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_alu_ctrl_sequencer;

  localparam int ALUOP_W  = 4;
  localparam int FUNCT_W  = 6;
  localparam int CTRL_W   = 4;
  localparam int MULT_LAT = 4;
  localparam int ERR_W    = 8;

  localparam int K_VALID   = 0;
  localparam int K_ILLEGAL = 1;
  localparam int K_SILENT  = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               valid_i = 1'b0;
  logic               flush_i = 1'b0;
  logic [ALUOP_W-1:0] aluop = '0;
  logic [FUNCT_W-1:0] funct = '0;
  logic               ready_o;
  logic [CTRL_W-1:0]  ALUCtrl_o;
  logic               valid_o;
  logic               busy_o;
  logic               illegal_o;
  logic [ERR_W-1:0]   err_cnt_o;

  typedef struct {
    logic [7:0] err;
    logic [3:0] ctrl;
  } ill_t;

  logic [3:0] exp_q[$];
  ill_t       ill_q[$];
  logic [3:0] model_ctrl = 4'd0;
  logic [7:0] model_err  = 8'd0;
  int         checks = 0;
  int         errors = 0;

  logic [3:0] tbl_op[9]   = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd15};
  logic [3:0] tbl_ctrl[9] = '{4'b0010, 4'b0110, 4'b0011, 4'b0010, 4'b0111,
                              4'b0100, 4'b0101, 4'b0000, 4'b0000};

  alu_ctrl_sequencer #(
    .ALUOP_W  (ALUOP_W),
    .FUNCT_W  (FUNCT_W),
    .CTRL_W   (CTRL_W),
    .MULT_LAT (MULT_LAT),
    .ERR_W    (ERR_W)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .ALUOp_i   (aluop),
    .funct_i   (funct),
    .flush_i   (flush_i),
    .ALUCtrl_o (ALUCtrl_o),
    .valid_o   (valid_o),
    .busy_o    (busy_o),
    .illegal_o (illegal_o),
    .err_cnt_o (err_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [3:0] e;
    ill_t       ie;
    if (rst_n) begin
      chk("no_valid_and_illegal", {31'd0, valid_o & illegal_o}, 32'd0);
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {31'd0, valid_o}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("valid_ctrl", {28'd0, ALUCtrl_o}, {28'd0, e});
        end
      end
      if (illegal_o) begin
        if (ill_q.size() == 0) begin
          chk("unexpected_illegal", {31'd0, illegal_o}, 32'd0);
        end else begin
          ie = ill_q.pop_front();
          chk("illegal_errcnt", {24'd0, err_cnt_o}, {24'd0, ie.err});
          chk("illegal_ctrl_hold", {28'd0, ALUCtrl_o}, {28'd0, ie.ctrl});
        end
      end
    end
  end

  // Present a request, wait (bounded) for ready, record the expected response, cross the accept edge.
  task automatic send(input logic [3:0] op, input logic [5:0] f, input int kind,
                      input logic [3:0] ectrl);
    int n = 0;
    aluop   = op;
    funct   = f;
    valid_i = 1'b1;
    @(negedge clk);
    while (!ready_o && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!ready_o) begin
      chk("send_ready_timeout", {31'd0, ready_o}, 32'd1);
    end else begin
      case (kind)
        K_VALID: begin
          exp_q.push_back(ectrl);
          model_ctrl = ectrl;
        end
        K_ILLEGAL: begin
          if (model_err != 8'hFF) model_err = model_err + 8'd1;
          ill_q.push_back('{model_err, model_ctrl});
        end
        default: model_ctrl = ectrl;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    valid_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctrl"},    {28'd0, ALUCtrl_o}, 32'd0);
    chk({tag, "_valid"},   {31'd0, valid_o},   32'd0);
    chk({tag, "_busy"},    {31'd0, busy_o},    32'd0);
    chk({tag, "_illegal"}, {31'd0, illegal_o}, 32'd0);
    chk({tag, "_errcnt"},  {24'd0, err_cnt_o}, 32'd0);
    chk({tag, "_ready"},   {31'd0, ready_o},   32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    #3;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back single-cycle R-type ops
    send(4'd2, 6'd32, K_VALID, 4'b0010);
    send(4'd2, 6'd34, K_VALID, 4'b0110);
    send(4'd2, 6'd42, K_VALID, 4'b0111);
    valid_i = 1'b0;
    @(negedge clk);
    chk("t1_ready", {31'd0, ready_o}, 32'd1);
    @(posedge clk);
    #1;

    // Multiply occupies the ALU for MULT_LAT cycles while an add waits
    send(4'd2, 6'd24, K_VALID, 4'b1000);
    aluop   = 4'd2;
    funct   = 6'd32;
    valid_i = 1'b1;
    for (int i = 0; i < MULT_LAT; i++) begin
      @(negedge clk);
      chk("t2_busy",  {31'd0, busy_o},    32'd1);
      chk("t2_ready", {31'd0, ready_o},   32'd0);
      chk("t2_ctrl",  {28'd0, ALUCtrl_o}, 32'd8);
      chk("t2_valid", {31'd0, valid_o},   (i == MULT_LAT - 1) ? 32'd1 : 32'd0);
    end
    send(4'd2, 6'd32, K_VALID, 4'b0010);
    idle_cycle();

    // Illegal funct holds the control word and counts, saturating
    send(4'd2, 6'd0, K_ILLEGAL, 4'b0000);
    idle_cycle();
    chk("t3_errcnt_one", {24'd0, err_cnt_o}, 32'd1);
    for (int i = 0; i < 300; i++) send(4'd2, 6'd0, K_ILLEGAL, 4'b0000);
    idle_cycle();
    @(negedge clk);
    chk("t3_errcnt_sat", {24'd0, err_cnt_o}, 32'd255);
    chk("t3_ctrl_hold",  {28'd0, ALUCtrl_o}, 32'd2);
    @(posedge clk);
    #1;

    // Flush during multiply drops the pending request and suppresses valid_o
    send(4'd2, 6'd24, K_SILENT, 4'b1000);
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    flush_i = 1'b1;
    valid_i = 1'b1;
    aluop   = 4'd1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    chk("t4_busy",  {31'd0, busy_o},    32'd0);
    chk("t4_ready", {31'd0, ready_o},   32'd1);
    chk("t4_ctrl",  {28'd0, ALUCtrl_o}, 32'd8);
    chk("t4_valid", {31'd0, valid_o},   32'd0);
    repeat (5) idle_cycle();
    send(4'd1, 6'd0, K_VALID, 4'b0110);
    idle_cycle();

    // Flush in IDLE beats a same-cycle request
    flush_i = 1'b1;
    valid_i = 1'b1;
    aluop   = 4'd0;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    chk("t4_idle_flush_ctrl",  {28'd0, ALUCtrl_o}, 32'd6);
    chk("t4_idle_flush_valid", {31'd0, valid_o},   32'd0);
    @(posedge clk);
    #1;

    // Non-R-type decode table, including out-of-range ALUOp
    for (int i = 0; i < 9; i++) send(tbl_op[i], 6'd0, K_VALID, tbl_ctrl[i]);
    idle_cycle();
    idle_cycle();

    // Asynchronous reset in the middle of a multiply
    send(4'd2, 6'd24, K_SILENT, 4'b1000);
    idle_cycle();
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6");
    model_ctrl = 4'd0;
    model_err  = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(4'd0, 6'd0, K_VALID, 4'b0010);
    repeat (6) idle_cycle();

    chk("pending_valid_empty",   exp_q.size(), 32'd0);
    chk("pending_illegal_empty", ill_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
